// File: rtl/demux_deser_nch.sv
// demux_deser_nch: gathers DATA_W-bit beats into DATA_W*RATIO-bit words after
// aligning on a SYNC_CHAR preamble, then deals words round-robin onto NUM_CH lanes.
// Optional saturating framing-error counter: define DEMUX_ERR_COUNT_EN.
module demux_deser_nch #(
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       RATIO      = 4,
    parameter int unsigned       NUM_CH     = 2,
    parameter logic [DATA_W-1:0] SYNC_CHAR  = DATA_W'(8'hBC),
    parameter int unsigned       SYNC_COUNT = 4
) (
    input  logic                       clk_4f,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       valid_in,
    output logic [NUM_CH*DATA_W*RATIO-1:0] data_out,
    output logic [NUM_CH-1:0]          valid_out,
    output logic                       aligned_out,
    output logic                       err_out
`ifdef DEMUX_ERR_COUNT_EN
    ,
    output logic [7:0]                 err_count
`endif
);

    localparam int unsigned OUT_W = DATA_W * RATIO;
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned BC_W  = $clog2(RATIO);
    localparam int unsigned SC_W  = $clog2(SYNC_COUNT + 1);

    typedef enum logic {
        SEARCH  = 1'b0,
        ALIGNED = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [SC_W-1:0]         sync_cnt_q, sync_cnt_d;
    logic [BC_W-1:0]         beat_cnt_q, beat_cnt_d;
    logic [CH_W-1:0]         ch_ptr_q, ch_ptr_d;
    logic [OUT_W-1:0]        acc_q, acc_d;
    logic [NUM_CH*OUT_W-1:0] lanes_q, lanes_d;
    logic [NUM_CH-1:0]       valid_q, valid_d;
    logic                    err_q, err_d;
    logic                    is_sync;

    assign is_sync = (data_in == SYNC_CHAR);

    // Next-state: preamble search, word accumulation, lane dealing, framing errors.
    always_comb begin
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        beat_cnt_d = beat_cnt_q;
        ch_ptr_d   = ch_ptr_q;
        acc_d      = acc_q;
        lanes_d    = lanes_q;
        valid_d    = '0;
        err_d      = 1'b0;

        if (valid_in) begin
            case (state_q)
                SEARCH: begin
                    if (is_sync) begin
                        if (sync_cnt_q == SC_W'(SYNC_COUNT - 1)) begin
                            state_d    = ALIGNED;
                            sync_cnt_d = '0;
                        end else begin
                            sync_cnt_d = sync_cnt_q + 1'b1;
                        end
                    end else begin
                        sync_cnt_d = '0;
                    end
                end
                ALIGNED: begin
                    if (is_sync) begin
                        // Sync at a word boundary is idle filler; mid-word it drops the partial word.
                        if (beat_cnt_q != '0) begin
                            err_d      = 1'b1;
                            acc_d      = '0;
                            beat_cnt_d = '0;
                        end
                    end else begin
                        for (int unsigned b = 0; b < RATIO; b++) begin
                            if (beat_cnt_q == BC_W'(b)) begin
                                acc_d[(RATIO-1-b)*DATA_W +: DATA_W] = data_in;
                            end
                        end
                        if (beat_cnt_q == BC_W'(RATIO - 1)) begin
                            for (int unsigned c = 0; c < NUM_CH; c++) begin
                                if (ch_ptr_q == CH_W'(c)) begin
                                    lanes_d[c*OUT_W +: OUT_W] = acc_d;
                                    valid_d[c]                = 1'b1;
                                end
                            end
                            beat_cnt_d = '0;
                            ch_ptr_d   = (ch_ptr_q == CH_W'(NUM_CH - 1)) ? '0 : ch_ptr_q + 1'b1;
                        end else begin
                            beat_cnt_d = beat_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            state_q    <= SEARCH;
            sync_cnt_q <= '0;
            beat_cnt_q <= '0;
            ch_ptr_q   <= '0;
            acc_q      <= '0;
            lanes_q    <= '0;
            valid_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_cnt_q <= sync_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            ch_ptr_q   <= ch_ptr_d;
            acc_q      <= acc_d;
            lanes_q    <= lanes_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign data_out    = lanes_q;
    assign valid_out   = valid_q;
    assign aligned_out = (state_q == ALIGNED);
    assign err_out     = err_q;

`ifdef DEMUX_ERR_COUNT_EN
    logic [7:0] err_count_q, err_count_d;
    logic       broken_pre;

    // Count framing errors and broken preambles, saturating at 8'hFF.
    always_comb begin
        broken_pre  = valid_in && (state_q == SEARCH) && !is_sync && (sync_cnt_q != '0);
        err_count_d = err_count_q;
        if ((err_d || broken_pre) && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_demux_deser_nch.sv
// Scoreboard bench for demux_deser_nch with default parameters.
// Stimulus pushes expected (lane, word) pairs; a negedge monitor pops and compares.
module tb_demux_deser_nch;

    localparam int DATA_W = 8;
    localparam int RATIO  = 4;
    localparam int NUM_CH = 2;
    localparam int OUT_W  = DATA_W * RATIO;

    logic                    clk_4f = 1'b0;
    logic                    reset;
    logic [DATA_W-1:0]       data_in;
    logic                    valid_in;
    logic [NUM_CH*OUT_W-1:0] data_out;
    logic [NUM_CH-1:0]       valid_out;
    logic                    aligned_out;
    logic                    err_out;
`ifdef DEMUX_ERR_COUNT_EN
    logic [7:0]              err_count;
`endif

    demux_deser_nch #(
        .DATA_W    (DATA_W),
        .RATIO     (RATIO),
        .NUM_CH    (NUM_CH),
        .SYNC_CHAR (8'hBC),
        .SYNC_COUNT(4)
    ) dut (
        .clk_4f     (clk_4f),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .aligned_out(aligned_out),
        .err_out    (err_out)
`ifdef DEMUX_ERR_COUNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    always #5 clk_4f = ~clk_4f;

    typedef struct {
        int          lane;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   err_seen = 0;
    int   err_exp  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: counts err pulses and pops the scoreboard on every valid_out.
    always @(negedge clk_4f) begin
        if (!reset) begin
            if (err_out) err_seen++;
            if (valid_out != '0) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid_out: got valid_out=%b data_out=%h, expected no output (t=%0t)",
                             valid_out, data_out, $time);
                end else begin
                    mon_e = sb.pop_front();
                    check("valid_out_lane", 64'(valid_out), 64'(NUM_CH'(1) << mon_e.lane));
                    check("lane_data", 64'(data_out[mon_e.lane*OUT_W +: OUT_W]), 64'(mon_e.data));
                end
            end
        end
    end

    task automatic beat(input logic [7:0] d);
        data_in  = d;
        valid_in = 1'b1;
        @(posedge clk_4f);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) begin
            @(posedge clk_4f);
            #1;
        end
    endtask

    task automatic align();
        repeat (4) beat(8'hBC);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;
        repeat (2) @(posedge clk_4f);
        #1;
        reset = 1'b0;
    endtask

    task automatic push(input int lane, input logic [31:0] d);
        exp_t e;
        e.lane = lane;
        e.data = d;
        sb.push_back(e);
    endtask

    initial begin
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;
        #1;

        // Reset state
        do_reset();
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_aligned", 64'(aligned_out), 64'd0);
        check("rst_err", 64'(err_out), 64'd0);

        // Basic alignment and two words dealt to lane0 then lane1
        repeat (3) beat(8'hBC);
        check("aligned_after_3_sync", 64'(aligned_out), 64'd0);
        beat(8'hBC);
        check("aligned_after_4_sync", 64'(aligned_out), 64'd1);
        push(0, 32'h01020304);
        push(1, 32'h05060708);
        for (int i = 1; i <= 8; i++) beat(8'(i));
        idle(1);
        check("lane0_held", 64'(data_out[0 +: OUT_W]), 64'h01020304);
        check("lane1_word", 64'(data_out[OUT_W +: OUT_W]), 64'h05060708);

        // Broken preamble restarts the sync count
        do_reset();
        begin
            logic [7:0] pre [8];
            pre = '{8'hBC, 8'hBC, 8'hBC, 8'h55, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
            for (int i = 0; i < 8; i++) begin
                beat(pre[i]);
                check($sformatf("preamble_aligned_beat%0d", i), 64'(aligned_out), (i == 7) ? 64'd1 : 64'd0);
            end
        end

        // Gaps mid-word hold the partial word
        push(0, 32'hAABBCCDD);
        beat(8'hAA);
        beat(8'hBB);
        idle(3);
        beat(8'hCC);
        beat(8'hDD);
        idle(1);
        check("gap_err_pulses", 64'(err_seen), 64'(err_exp));

        // Framing error mid-word: partial dropped, lane pointer unchanged
        do_reset();
        align();
        beat(8'h11);
        beat(8'h22);
        beat(8'hBC);
        err_exp++;
        check("framing_err_pulse", 64'(err_out), 64'd1);
        push(0, 32'h33445566);
        beat(8'h33);
        check("framing_err_one_cycle", 64'(err_out), 64'd0);
        beat(8'h44);
        beat(8'h55);
        beat(8'h66);
        // Idle filler at a word boundary has no effect
        beat(8'hBC);
        push(1, 32'h778899AA);
        beat(8'h77);
        beat(8'h88);
        beat(8'h99);
        beat(8'hAA);
        idle(1);
        check("filler_err_pulses", 64'(err_seen), 64'(err_exp));
        check("aligned_after_filler", 64'(aligned_out), 64'd1);

        // Asynchronous reset mid-word
        beat(8'h12);
        beat(8'h34);
        reset = 1'b1;
        #1;
        check("async_rst_data_out", 64'(data_out), 64'd0);
        check("async_rst_aligned", 64'(aligned_out), 64'd0);
        check("async_rst_valid_out", 64'(valid_out), 64'd0);
        @(posedge clk_4f);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) beat(8'h40 + 8'(i));
        check("no_align_without_preamble", 64'(aligned_out), 64'd0);
        align();
        push(0, 32'hA1A2A3A4);
        beat(8'hA1);
        beat(8'hA2);
        beat(8'hA3);
        beat(8'hA4);
        idle(1);

`ifdef DEMUX_ERR_COUNT_EN
        // Error counter: broken preamble, then saturation under 300 framing errors
        do_reset();
        check("err_count_reset", 64'(err_count), 64'd0);
        beat(8'hBC);
        beat(8'h55);
        check("err_count_broken_preamble", 64'(err_count), 64'd1);
        align();
        for (int i = 0; i < 300; i++) begin
            beat(8'h11);
            beat(8'hBC);
            err_exp++;
        end
        idle(1);
        check("err_count_saturated", 64'(err_count), 64'hFF);
`endif

        idle(2);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        check("total_err_pulses", 64'(err_seen), 64'(err_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_deser_nch.md
Name: demux_deser_nch

Overview:
- Parametrised successor to the 8-to-32 demux. Gathers a DATA_W-bit beat stream on clk_4f into DATA_W*RATIO-bit words.
- Aligns to a sync-character preamble, then deals completed words round-robin onto NUM_CH output lanes.
- Sits between the serial-side receiver and the per-lane wide datapath.

Parameters:
DATA_W, 8, beat width in bits
RATIO, 4, beats per output word (>=2); OUT_W = DATA_W*RATIO
NUM_CH, 2, number of output lanes (>=1); CH_W = max(1, clog2(NUM_CH))
SYNC_CHAR, 8'hBC, alignment/idle character, DATA_W bits wide
SYNC_COUNT, 4, consecutive sync beats needed to align (>=1)

Ports:
clk_4f  in  1  beat clock; all state changes on its rising edge
reset  in  1  asynchronous, active-high reset
data_in  in  DATA_W  input beat
valid_in  in  1  data_in is valid this cycle
data_out  out  NUM_CH*OUT_W  lane c occupies bits [c*OUT_W +: OUT_W]
valid_out  out  NUM_CH  one-cycle pulse per lane when its word updates
aligned_out  out  1  high while FSM is in ALIGNED
err_out  out  1  one-cycle pulse on framing error

Behaviour:
- Reset (async assert, sync release): state=SEARCH, sync_cnt=0, beat_cnt=0, ch_ptr=0, shift register=0; all outputs 0.
- Cycles with valid_in=0 change no state or counters. valid_out and err_out are 0 in the cycle after such an edge.
- SEARCH state:
  - Valid beat == SYNC_CHAR: sync_cnt++.
  - Valid beat != SYNC_CHAR: sync_cnt=0.
  - When sync_cnt reaches SYNC_COUNT, go to ALIGNED on that edge; sync_cnt clears.
  - Data beats are discarded.
- ALIGNED state:
  - Valid beat == SYNC_CHAR with beat_cnt==0: idle filler, discarded, no other effect.
  - Valid beat == SYNC_CHAR with beat_cnt!=0: framing error. err_out pulses next cycle, the partial word is dropped, beat_cnt=0, ch_ptr unchanged, state stays ALIGNED.
  - Any other valid beat is accumulated, first beat into the MSBs: beat 0 -> bits [OUT_W-1 -: DATA_W], and so on. beat_cnt++.
  - On the edge sampling beat RATIO-1:
    - The full word is loaded into lane ch_ptr.
    - valid_out[ch_ptr]=1 for exactly one cycle.
    - beat_cnt=0.
    - ch_ptr = (ch_ptr==NUM_CH-1) ? 0 : ch_ptr+1.
  - Latency: word visible in the cycle immediately after the edge sampling its last beat.
- Other lanes hold their last word. Lane data is never cleared except by reset.
- Gaps (valid_in=0) mid-word are legal; the partial word is held.
- Reset mid-word: partial word is lost; the FSM must realign (SYNC_COUNT sync beats) before any output.
- At most one valid_out bit is high in any cycle.
- NUM_CH=1: ch_ptr stays 0.

Optional Feature:
- Macro: DEMUX_ERR_COUNT_EN.
- Defined:
  - Extra output port err_count (8 bits), reset 0.
  - Increments on every framing error and saturates at 8'hFF.
  - Also increments when a valid non-sync beat arrives in SEARCH after at least one sync beat has been counted (broken preamble).
- Undefined: port absent, no counter logic; all other behaviour identical.

Test Plan:
- Reset then 4x 8'hBC, then 8 beats 01..08 (defaults):
  - valid_out=2'b01 with lane0 = 32'h01020304.
  - Next word: valid_out=2'b10 with lane1 = 32'h05060708.
  - aligned_out=1 from the cycle after the 4th BC.
- Preamble BC,BC,BC,55,BC,BC,BC,BC: aligned_out rises only after the 8th beat, not the 4th.
- Aligned, beats AA,BB with valid_in=0 for 3 cycles, then CC,DD: lane0 = 32'hAABBCCDD; no err_out.
- Aligned, beats 11,22,BC:
  - err_out pulses once; no valid_out.
  - Next 4 beats 33,44,55,66 land on lane0 (ch_ptr not advanced) = 32'h33445566.
- Assert reset mid-word after 2 beats:
  - All outputs go 0 immediately (asynchronous).
  - After release, data beats without a preamble produce no valid_out.
- With DEMUX_ERR_COUNT_EN defined:
  - 300 injected framing errors -> err_count saturates at 8'hFF.
  - Same stimulus with the macro undefined compiles with no err_count port.
